// File: rtl/if_id_if.sv
// if_id_if -- fetch/decode boundary signals between the PC stage, the
// instruction memory and the IF/ID slot.
//   master : PC stage side, drives pc_in / ins_in and observes the slot
//   slave  : if_id side, samples pc_in / ins_in and drives the slot outputs
//   pc_in      word-addressed fetch PC
//   ins_in     instruction memory read data for pc_in
//   ins_d      registered instruction (0 for a bubble)
//   pc_d       registered PC of ins_d
//   valid_d    decode slot holds a live instruction
//   op_d       ins_d[31:26]
//   addr_d     ins_d[25:0], jump target byte address
//   jon_d      01 jump, 10 branch / register jump, 00 none
//   fetch_cnt  live captures
//   bubble_cnt squashed captures
interface if_id_if;
  logic [31:0] pc_in;
  logic [31:0] ins_in;
  logic [31:0] ins_d;
  logic [31:0] pc_d;
  logic        valid_d;
  logic [5:0]  op_d;
  logic [25:0] addr_d;
  logic [1:0]  jon_d;
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;

  modport master (
    output pc_in, ins_in,
    input  ins_d, pc_d, valid_d, op_d, addr_d, jon_d, fetch_cnt, bubble_cnt
  );

  modport slave (
    input  pc_in, ins_in,
    output ins_d, pc_d, valid_d, op_d, addr_d, jon_d, fetch_cnt, bubble_cnt
  );
endinterface

// File: rtl/if_id.sv
// if_id -- IF/ID pipeline slot with control-transfer squash.
// Captures the fetched instruction every edge; after a jump one following
// capture is squashed, after a branch three are squashed so the resolved
// target arrives on the fourth capture.
//   clk   clock, rising edge
//   rstd  asynchronous active-low reset
//   bus   if_id_if.slave (pc_in/ins_in in; slot, decode and counters out)
//
// state | meaning
// IDLE  | normal fetch; capture is live unless jon_d is non-zero
// SQ2   | branch squash, two more bubbles to go after this edge's one
// SQ1   | branch squash, last bubble
module if_id (
  input  logic clk,
  input  logic rstd,
  if_id_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQ2  = 2'd1,
    SQ1  = 2'd2
  } sq_state_t;

  sq_state_t   state_q, state_nxt;
  logic [31:0] ins_q;
  logic [31:0] pc_q;
  logic        valid_q;
  logic [31:0] fetch_q;
  logic [31:0] bubble_q;
  logic [5:0]  op;
  logic [1:0]  jon;
  logic        live;

  assign op = ins_q[31:26];

  // Bubbles hold ins_q = 0 and valid_q = 0, so they can never decode a transfer.
  always_comb begin
    jon = 2'b00;
    if (valid_q) begin
      case (op)
        6'd40, 6'd41:                      jon = 2'b01;
        6'd32, 6'd33, 6'd34, 6'd35, 6'd42: jon = 2'b10;
        default:                           jon = 2'b00;
      endcase
    end
  end

  always_comb begin
    state_nxt = state_q;
    live      = 1'b0;
    case (state_q)
      IDLE: begin
        live = (jon == 2'b00);
        if (jon == 2'b10) state_nxt = SQ2;
      end
      SQ2:     state_nxt = SQ1;
      SQ1:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) state_q <= IDLE;
    else       state_q <= state_nxt;
  end

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      ins_q    <= 32'h0;
      pc_q     <= 32'h0;
      valid_q  <= 1'b0;
      fetch_q  <= 32'h0;
      bubble_q <= 32'h0;
    end else begin
      pc_q <= bus.pc_in;
      if (live) begin
        ins_q   <= bus.ins_in;
        valid_q <= 1'b1;
        fetch_q <= fetch_q + 32'd1;
      end else begin
        ins_q    <= 32'h0;
        valid_q  <= 1'b0;
        bubble_q <= bubble_q + 32'd1;
      end
    end
  end

  assign bus.ins_d      = ins_q;
  assign bus.pc_d       = pc_q;
  assign bus.valid_d    = valid_q;
  assign bus.op_d       = op;
  assign bus.addr_d     = ins_q[25:0];
  assign bus.jon_d      = jon;
  assign bus.fetch_cnt  = fetch_q;
  assign bus.bubble_cnt = bubble_q;

endmodule

// File: tb/tb_if_id.sv
// tb_if_id -- directed bench for if_id: reset state, straight-line fetch,
// jump and branch squash, transfers presented during a squash, reset in
// the middle of a squash and fetch counter wrap.
module tb_if_id;
  logic clk;
  logic rstd;
  int   errors;
  int   checks;

  if_id_if bus ();

  if_id dut (
    .clk  (clk),
    .rstd (rstd),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Present one fetch, take one rising edge, settle just after it.
  task automatic tick(input logic [31:0] pc, input logic [31:0] ins);
    bus.pc_in  = pc;
    bus.ins_in = ins;
    @(posedge clk);
    #1;
  endtask

  task automatic check_slot(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                            input logic valid, input logic [1:0] jon);
    check({tag, ".pc_d"},    bus.pc_d, pc);
    check({tag, ".ins_d"},   bus.ins_d, ins);
    check({tag, ".valid_d"}, {31'd0, bus.valid_d}, {31'd0, valid});
    check({tag, ".jon_d"},   {30'd0, bus.jon_d}, {30'd0, jon});
  endtask

  task automatic check_cnt(input string tag, input logic [31:0] f, input logic [31:0] b);
    check({tag, ".fetch_cnt"},  bus.fetch_cnt, f);
    check({tag, ".bubble_cnt"}, bus.bubble_cnt, b);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rstd = 1'b0;
    bus.pc_in  = 32'h0;
    bus.ins_in = 32'h0;
    #12;
    check_slot("reset", 32'h0, 32'h0, 1'b0, 2'b00);
    check_cnt("reset", 32'd0, 32'd0);

    @(negedge clk);
    rstd = 1'b1;

    // straight-line fetch, first capture after release is live at pc 0
    tick(32'd0, 32'h0000_0000);
    check_slot("seq0", 32'd0, 32'h0000_0000, 1'b1, 2'b00);
    tick(32'd1, 32'h0000_0123);
    check_slot("seq1", 32'd1, 32'h0000_0123, 1'b1, 2'b00);
    tick(32'd2, 32'h0000_0456);
    check_slot("seq2", 32'd2, 32'h0000_0456, 1'b1, 2'b00);
    check_cnt("seq", 32'd3, 32'd0);

    // jump: j 0x40 at pc 5, one bubble, then live at 0x40>>2
    tick(32'd3, 32'h0000_0000);
    tick(32'd4, 32'h0000_0000);
    tick(32'd5, 32'hA000_0040);
    check_slot("jmp", 32'd5, 32'hA000_0040, 1'b1, 2'b01);
    check("jmp.op_d",   {26'd0, bus.op_d}, 32'd40);
    check("jmp.addr_d", {6'd0, bus.addr_d}, 32'h40);
    tick(32'd6, 32'h8C00_0000);
    check_slot("jmp_bub", 32'd6, 32'h0, 1'b0, 2'b00);
    tick(32'h10, 32'h0000_0011);
    check_slot("jmp_tgt", 32'h10, 32'h0000_0011, 1'b1, 2'b00);
    check_cnt("jmp", 32'd7, 32'd1);

    // branch: op 32 at pc 8, three bubbles carrying transfer opcodes
    tick(32'h11, 32'h0000_0000);
    tick(32'd8, 32'h8000_0000);
    check_slot("br", 32'd8, 32'h8000_0000, 1'b1, 2'b10);
    tick(32'd9, 32'h8400_0000);
    check_slot("br_bub1", 32'd9, 32'h0, 1'b0, 2'b00);
    tick(32'd10, 32'hA800_0000);
    check_slot("br_bub2", 32'd10, 32'h0, 1'b0, 2'b00);
    tick(32'd11, 32'h8000_0000);
    check_slot("br_bub3", 32'd11, 32'h0, 1'b0, 2'b00);
    tick(32'd20, 32'h0000_0055);
    check_slot("br_tgt", 32'd20, 32'h0000_0055, 1'b1, 2'b00);
    check_cnt("br", 32'd10, 32'd4);

    // op 43 is not a transfer; jal (op 41) squashes one capture
    tick(32'd21, 32'hAC00_0000);
    check_slot("op43", 32'd21, 32'hAC00_0000, 1'b1, 2'b00);
    tick(32'd22, 32'hA400_0080);
    check_slot("jal", 32'd22, 32'hA400_0080, 1'b1, 2'b01);
    check("jal.addr_d", {6'd0, bus.addr_d}, 32'h80);
    tick(32'd23, 32'h0000_0000);
    check_slot("jal_bub", 32'd23, 32'h0, 1'b0, 2'b00);
    check_cnt("jal", 32'd12, 32'd5);

    // reset while in SQ1 aborts the squash
    tick(32'd24, 32'h8800_0000);
    check_slot("br2", 32'd24, 32'h8800_0000, 1'b1, 2'b10);
    tick(32'd25, 32'h0000_0000);
    tick(32'd26, 32'h0000_0000);
    rstd = 1'b0;
    #1;
    check_slot("mid_rst", 32'h0, 32'h0, 1'b0, 2'b00);
    check_cnt("mid_rst", 32'd0, 32'd0);
    @(negedge clk);
    rstd = 1'b1;
    tick(32'd30, 32'h0000_0077);
    check_slot("post_rst", 32'd30, 32'h0000_0077, 1'b1, 2'b00);
    check_cnt("post_rst", 32'd1, 32'd0);

    // fetch counter wrap
    force dut.fetch_q = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_q;
    #1;
    check("wrap_pre", bus.fetch_cnt, 32'hFFFF_FFFF);
    tick(32'd31, 32'h0000_0000);
    check_cnt("wrap", 32'd0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/if_id.md
IF_ID -- requirements
Module: if_id

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  clock; all state updates on rising edge.
- rstd  in  1  reset, asynchronous, active-low.
- pc_in  in  32  word-addressed fetch PC currently presented by the PC stage.
- ins_in  in  32  instruction memory read data for pc_in, combinational, same cycle.
- ins_d  out  32  registered instruction in decode; 32'h0 when the slot is a bubble.
- pc_d  out  32  registered PC of ins_d.
- valid_d  out  1  decode slot holds a live instruction.
- op_d  out  6  ins_d[31:26].
- addr_d  out  26  ins_d[25:0], the jump target byte address.
- jon_d  out  2  control-transfer flag to the PC stage: 01 = jump, 10 = branch or register jump, 00 = none.
- fetch_cnt  out  32  count of live instructions captured.
- bubble_cnt  out  32  count of squashed captures.

Function
REQ-002 On every rising clk edge the block SHALL capture pc_in into pc_d, and ins_in into ins_d when the capture is live.
REQ-003 A capture SHALL be live only when the squash FSM is in IDLE and jon_d is 00 at that edge; otherwise ins_d SHALL load 32'h0 and valid_d SHALL load 0.
REQ-004 op_d and addr_d SHALL be combinational slices of ins_d.
REQ-005 jon_d SHALL be combinational from the registered slot and SHALL be 00 whenever valid_d is 0.
REQ-006 When valid_d is 1, jon_d SHALL be 01 for op_d 40 (j) or 41 (jal).
REQ-007 When valid_d is 1, jon_d SHALL be 10 for op_d 32, 33, 34, 35 or 42.
REQ-008 When valid_d is 1 and op_d is any other value, jon_d SHALL be 00.
REQ-009 The squash FSM SHALL have the states IDLE, SQ2 and SQ1.
REQ-010 In IDLE, when jon_d is 10 the FSM SHALL go to SQ2 and the edge SHALL capture a bubble; when jon_d is 01 it SHALL stay in IDLE and the edge SHALL capture a bubble.
REQ-011 From SQ2 the FSM SHALL go to SQ1, and from SQ1 to IDLE; each of these edges SHALL capture a bubble.
REQ-012 A branch SHALL therefore produce exactly 3 bubbles (PCs P+1, P+2, P+3), and the 4th capture SHALL be the resolved target.
REQ-013 A jump SHALL produce exactly 1 bubble (PC P+1), and the next capture SHALL be at PC addr_d>>2.
REQ-014 A bubble SHALL never assert jon_d, so no transfer can be decoded while a squash is in progress.
REQ-015 fetch_cnt SHALL increment by 1 on each live capture.
REQ-016 bubble_cnt SHALL increment by 1 on each bubble capture.
REQ-017 Exactly one of fetch_cnt and bubble_cnt SHALL increment per edge.
REQ-018 Both counters SHALL wrap modulo 2^32 with no saturation and no flag.

Reset
REQ-019 While rstd=0, asynchronously: ins_d=0, pc_d=0, valid_d=0, jon_d=00, FSM=IDLE, fetch_cnt=0, bubble_cnt=0.
REQ-020 The first rising edge after rstd deasserts SHALL be a live capture of pc_in=0.
REQ-021 Asserting rstd mid-squash (SQ2 or SQ1) SHALL abort the squash, and the next capture after release SHALL be live.

Verification
REQ-022 Reset release, pc_in 0,1,2 with ins_in of op 0 -> valid_d=1 with pc_d 0,1,2; fetch_cnt=3; bubble_cnt=0.
REQ-023 Live ins 0xA0000040 (op 40, addr 0x40) at pc_d 5 -> jon_d=01 and addr_d=0x40; the next capture is a bubble (ins_d=0, valid_d=0); the following capture is live at pc_d 0x10.
REQ-024 Live op 32 at pc_d 8 -> jon_d=10 for one cycle; the next 3 captures are bubbles with pc_d 9, 10, 11; the 4th capture is live; bubble_cnt +3.
REQ-025 A branch instruction presented on ins_in during the squash window -> captured as a bubble, and jon_d stays 00.
REQ-026 rstd pulsed low while the FSM is in SQ1 -> all outputs read 0 immediately; after release the first capture is live.
REQ-027 fetch_cnt preloaded (via force) to 0xFFFFFFFF, then one live capture -> fetch_cnt=0.
